multicycle_ctrl: RTL and testbench

Moore control FSM that sequences the multicycle MIPS-subset datapath. Each cycle it drives the select lines of the datapath's 2:1 and 4:1 multiplexers, the ALU operation class, and the architectural write strobes. The writeback 4:1 mux uses `wb_sel`, and the PC-source 4:1 mux uses `pc_src`. The block sits between the instruction register (opcode/funct) and the register file, memory and PC write enables.

---
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS-subset datapath: sequences mux
// selects, ALU op class and write strobes from the instruction opcode.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    JAL    = 4'd12
  } state_t;

  state_t state, next_state;

  logic pc_write_raw, pc_write_cond_raw, mem_write_raw, ir_write_raw;
  logic reg_write_raw, instr_done_raw, illegal_raw, gate;

  // The zero flag is consumed by the datapath's PC-enable logic, not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (en) begin
      case (state)
        FETCH:  next_state = DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: next_state = MEMADR;
            OP_R:         next_state = EXEC;
            OP_BEQ:       next_state = BRANCH;
            OP_ADDI:      next_state = ADDIEX;
            OP_J:         next_state = JUMP;
            OP_JAL:       next_state = JAL;
            default:      next_state = FETCH;
          endcase
        end
        MEMADR: next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  next_state = MEMWB;
        EXEC:   next_state = ALUWB;
        ADDIEX: next_state = ADDIWB;
        default: next_state = FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    instr_done_raw    = 1'b0;
    illegal_raw       = 1'b0;
    iord              = 1'b0;
    reg_dst           = 2'b00;
    wb_sel            = 2'b00;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    alu_op            = 2'b00;
    pc_src            = 2'b00;
    case (state)
      FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b01;
        pc_write_raw = 1'b1;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL: illegal_raw = 1'b0;
          default: illegal_raw = 1'b1;
        endcase
      end
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        reg_write_raw  = 1'b1;
        wb_sel         = 2'b01;
        instr_done_raw = 1'b1;
      end
      MEMWR: begin
        iord           = 1'b1;
        mem_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write_raw  = 1'b1;
        reg_dst        = 2'b01;
        instr_done_raw = 1'b1;
      end
      ADDIWB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      BRANCH: begin
        alu_src_a         = 1'b1;
        alu_op            = 2'b01;
        pc_src            = 2'b01;
        pc_write_cond_raw = 1'b1;
        instr_done_raw    = 1'b1;
      end
      JUMP: begin
        pc_src         = 2'b10;
        pc_write_raw   = 1'b1;
        instr_done_raw = 1'b1;
      end
      JAL: begin
        pc_src         = 2'b10;
        pc_write_raw   = 1'b1;
        reg_write_raw  = 1'b1;
        reg_dst        = 2'b10;
        wb_sel         = 2'b10;
        instr_done_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are killed combinationally so a frozen or resetting FSM never writes.
  assign gate          = en & rst_n;
  assign pc_write      = pc_write_raw & gate;
  assign pc_write_cond = pc_write_cond_raw & gate;
  assign mem_write     = mem_write_raw & gate;
  assign ir_write      = ir_write_raw & gate;
  assign reg_write     = reg_write_raw & gate;
  assign instr_done    = instr_done_raw & gate;
  assign illegal_op    = illegal_raw & gate;
  assign state_o       = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instruction streams with stalls, checked against a behavioural model.
module tb_multicycle_ctrl;

  typedef int int_q_t[$];

  logic       clk, rst_n, en, zero;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, iord, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, wb_sel, alu_src_b, alu_op, pc_src;
  logic       alu_src_a, instr_done, illegal_op;
  logic [3:0] state_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic zero_val;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit isLegal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h03};
  endfunction

  // State path an instruction walks through, start to finish.
  function automatic int_q_t expSeq(input logic [5:0] op);
    int_q_t q;
    case (op)
      6'h23:   q = '{0, 1, 2, 3, 4};
      6'h2B:   q = '{0, 1, 2, 5};
      6'h00:   q = '{0, 1, 6, 7};
      6'h08:   q = '{0, 1, 9, 10};
      6'h04:   q = '{0, 1, 8};
      6'h02:   q = '{0, 1, 11};
      6'h03:   q = '{0, 1, 12};
      default: q = '{0, 1};
    endcase
    return q;
  endfunction

  // Expected output vector for a state, with strobes allowed only when live.
  function automatic logic [31:0] expOut(input int s, input logic live, input logic ill);
    logic pw, pwc, io, mw, irw, rw, asa, done;
    logic [1:0] rd, wb, asb, aop, psrc;
    {pw, pwc, io, mw, irw, rw, asa, done} = '0;
    {rd, wb, asb, aop, psrc} = '0;
    case (s)
      0:  begin irw = 1; asb = 2'b01; pw = 1; end
      1:  asb = 2'b11;
      2, 9: begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin rw = 1; wb = 2'b01; done = 1; end
      5:  begin io = 1; mw = 1; done = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; done = 1; end
      10: begin rw = 1; done = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pwc = 1; done = 1; end
      11: begin psrc = 2'b10; pw = 1; done = 1; end
      12: begin psrc = 2'b10; pw = 1; rw = 1; rd = 2'b10; wb = 2'b10; done = 1; end
      default: ;
    endcase
    return 32'({pw & live, pwc & live, io, mw & live, irw & live, rw & live, rd, wb,
                asa, asb, aop, psrc, done & live, ill & live});
  endfunction

  function automatic logic [31:0] obsVec();
    return 32'({pc_write, pc_write_cond, iord, mem_write, ir_write, reg_write, reg_dst,
                wb_sel, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op});
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle in state s; entered at posedge+1, leaves at next posedge+1.
  task automatic doCycle(input int s, input logic e);
    en   = e;
    zero = zero_val;
    @(negedge clk);
    checkOutput($sformatf("state_s%0d", s), 32'(state_o), 32'(s));
    checkOutput($sformatf("outputs_s%0d_en%0d", s, e), obsVec(),
                expOut(s, e, (s == 1) && !isLegal(opcode)));
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic z,
                               input int stall_at, input int stall_len);
    int_q_t seq;
    opcode   = op;
    zero_val = z;
    seq      = expSeq(op);
    foreach (seq[i]) begin
      if (seq[i] == stall_at)
        for (int k = 0; k < stall_len; k++) doCycle(seq[i], 1'b0);
      doCycle(seq[i], 1'b1);
    end
  endtask

  initial begin
    logic [5:0] op;
    int pick;
    rst_n = 1'b0; en = 1'b1; opcode = 6'h00; zero = 1'b0; zero_val = 1'b0;

    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_state", 32'(state_o), 32'd0);
      checkOutput("reset_outputs", obsVec(), expOut(0, 1'b0, 1'b0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(6'h23, 1'b0, -1, 0);
    applyStimulus(6'h04, 1'b1, -1, 0);
    applyStimulus(6'h04, 1'b0, -1, 0);
    applyStimulus(6'h03, 1'b0, -1, 0);
    applyStimulus(6'h3F, 1'b0, -1, 0);
    applyStimulus(6'h2B, 1'b0, 5, 4);

    // Abort an R-type in its writeback state with an asynchronous reset.
    opcode = 6'h00;
    zero_val = 1'b0;
    doCycle(0, 1'b1);
    doCycle(1, 1'b1);
    doCycle(6, 1'b1);
    en = 1'b1;
    #1;
    checkOutput("abort_pre_reg_write", 32'(reg_write), 32'd1);
    checkOutput("abort_pre_state", 32'(state_o), 32'd7);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_state", 32'(state_o), 32'd0);
    checkOutput("abort_outputs", obsVec(), expOut(0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    checkOutput("abort_hold_state", 32'(state_o), 32'd0);
    checkOutput("abort_hold_outputs", obsVec(), expOut(0, 1'b0, 1'b0));
    rst_n = 1'b1;

    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 7);
      case (pick)
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h02;
        6: op = 6'h03;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (isLegal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      applyStimulus(op, 1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
